// File: rtl/rv32i_types.sv
// Shared mp0 type package: RV32I opcodes plus the memory responder state and sizing constants.
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // Largest supported responder latency; sizes the down-counter.
   localparam int MEM_MAX_LATENCY = 15;
   localparam int MEM_CNT_WIDTH   = $clog2(MEM_MAX_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } mem_resp_state_t;

endpackage

// File: rtl/byte_ram.sv
// Word-organized storage with per-byte write strobes and a registered, enable-gated read port.
module byte_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  re,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read data only moves on an enabled read so it holds across writes and idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding-request memory responder for mp0: fixed-latency response, byte-masked writes,
// sticky protocol error detection.
module memory_responder
   import rv32i_types::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic        mem_resp,
   output logic [31:0] mem_rdata,
   output logic        protocol_err
);

   localparam logic [MEM_CNT_WIDTH-1:0] CNT_INIT = MEM_CNT_WIDTH'(LATENCY - 1);
   localparam logic [MEM_CNT_WIDTH-1:0] CNT_ONE  = MEM_CNT_WIDTH'(1);

   mem_resp_state_t          state, state_next;
   logic [MEM_CNT_WIDTH-1:0] cnt, cnt_next;
   logic                     enter_resp;

   logic                  lat_read, lat_write;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [31:0]           lat_wdata;
   logic [3:0]            lat_be;

   logic                  req, from_idle;
   logic [ADDR_WIDTH-1:0] req_idx, commit_idx;
   logic                  commit_read, commit_write;
   logic [31:0]           commit_wdata;
   logic [3:0]            commit_be, ram_we;
   logic                  ram_re;
   logic                  unused_addr;

   assign req         = mem_read | mem_write;
   assign req_idx     = mem_address[ADDR_WIDTH+1:2];
   assign unused_addr = ^{mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};
   assign from_idle   = (state == IDLE);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               cnt_next = CNT_INIT;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // With LATENCY=1 the commit edge is the accept edge, so the live request is used instead of the latches.
   always_comb begin
      commit_idx   = from_idle ? req_idx : lat_idx;
      commit_write = from_idle ? mem_write : lat_write;
      commit_read  = from_idle ? (mem_read & ~mem_write) : lat_read;
      commit_wdata = from_idle ? mem_wdata : lat_wdata;
      commit_be    = from_idle ? mem_byte_enable : lat_be;
      ram_we       = (enter_resp && commit_write && rst_n) ? commit_be : 4'b0000;
      ram_re       = enter_resp && commit_read && rst_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         mem_resp     <= 1'b0;
         protocol_err <= 1'b0;
         lat_read     <= 1'b0;
         lat_write    <= 1'b0;
         lat_idx      <= '0;
         lat_wdata    <= '0;
         lat_be       <= '0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         mem_resp <= enter_resp;
         if (from_idle && req) begin
            lat_read  <= mem_read & ~mem_write;
            lat_write <= mem_write;
            lat_idx   <= req_idx;
            lat_wdata <= mem_wdata;
            lat_be    <= mem_byte_enable;
         end
         // A simultaneous read+write is served as a write but still flagged.
         if (from_idle && mem_read && mem_write) begin
            protocol_err <= 1'b1;
         end
         if (state == WAIT &&
             (req_idx != lat_idx || mem_read != lat_read || mem_write != lat_write)) begin
            protocol_err <= 1'b1;
         end
      end
   end

   byte_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .re   (ram_re),
      .we   (ram_we),
      .addr (commit_idx),
      .wdata(commit_wdata),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: two responders (LATENCY 3 and 1) driven with directed and random
// transactions and compared against a word-array reference model.
module tb_memory_responder;

   logic        clk;
   logic        rst_n;
   logic        rd     [2];
   logic        wr     [2];
   logic [3:0]  be     [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic        resp   [2];
   logic [31:0] rdata  [2];
   logic        err    [2];

   int          vectors;
   int          miscompares;
   int          lat_of [2];
   logic [31:0] model_mem [2][1024];
   bit          err_model [2];
   logic [31:0] last_rd [2];

   memory_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
      .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
      .mem_resp(resp[0]), .mem_rdata(rdata[0]), .protocol_err(err[0])
   );

   memory_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
      .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
      .mem_resp(resp[1]), .mem_rdata(rdata[1]), .protocol_err(err[1])
   );

   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'h3FF);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idleInputs(input int d);
      rd[d] = 1'b0; wr[d] = 1'b0; be[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
   endtask

   // One full request/response; chg swaps the address after the accept edge, hold keeps the request up through RESP.
   task automatic applyStimulus(input int d, input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] dat, input logic [3:0] b, input bit hold,
                                input bit chg, input logic [31:0] a2);
      int idx;
      idx = widx(a);
      rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat; be[d] = b;
      for (int k = 1; k <= lat_of[d]; k++) begin
         @(posedge clk); #1;
         if (chg && k == 1) addr[d] = a2;
         checkOutput($sformatf("resp_d%0d_cyc%0d", d, k), 32'(resp[d]), (k == lat_of[d]) ? 32'd1 : 32'd0);
      end
      if (w) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) model_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
         end
      end
      if (r && w) err_model[d] = 1'b1;
      if (chg && widx(a2) != idx) err_model[d] = 1'b1;
      if (r && !w) last_rd[d] = model_mem[d][idx];
      checkOutput($sformatf("rdata_d%0d", d), rdata[d], last_rd[d]);
      checkOutput($sformatf("perr_d%0d", d), 32'(err[d]), 32'(err_model[d]));
      if (!hold) idleInputs(d);
      @(posedge clk); #1;
      checkOutput($sformatf("resp_single_d%0d", d), 32'(resp[d]), 32'd0);
      if (hold) idleInputs(d);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         err_model[d] = 1'b0;
         last_rd[d]   = '0;
      end
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      vectors = 0;
      miscompares = 0;
      lat_of[0] = 3;
      lat_of[1] = 1;
      for (int d = 0; d < 2; d++) begin
         idleInputs(d);
         err_model[d] = 1'b0;
         last_rd[d] = '0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("rst_resp_d%0d", d), 32'(resp[d]), 32'd0);
         checkOutput($sformatf("rst_rdata_d%0d", d), rdata[d], 32'd0);
         checkOutput($sformatf("rst_perr_d%0d", d), 32'(err[d]), 32'd0);
      end
      releaseReset();

      $display("[TB] read after write, LATENCY=3");
      applyStimulus(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      applyStimulus(0, 1, 0, 32'h40, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("raw_const", rdata[0], 32'hDEADBEEF);

      $display("[TB] byte enables");
      applyStimulus(0, 0, 1, 32'h80, 32'h11223344, 4'hF, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h80, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
      applyStimulus(0, 1, 0, 32'h80, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("be_const", rdata[0], 32'h11BB33DD);
      applyStimulus(0, 0, 1, 32'h80, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
      applyStimulus(0, 1, 0, 32'h80, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("be_zero_const", rdata[0], 32'h11BB33DD);

      $display("[TB] LATENCY=1 fetch/load/store");
      applyStimulus(1, 0, 1, 32'h100, 32'h00A00093, 4'hF, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'h200, 32'h0BADF00D, 4'hF, 0, 0, 0);
      applyStimulus(1, 1, 0, 32'h100, 32'h0, 4'h0, 1, 0, 0);
      checkOutput("fetch_const", rdata[1], 32'h00A00093);
      applyStimulus(1, 1, 0, 32'h200, 32'h0, 4'h0, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'h300, 32'h13579BDF, 4'hF, 1, 0, 0);
      applyStimulus(1, 1, 0, 32'h300, 32'h0, 4'h0, 0, 0, 0);

      $display("[TB] aliasing and misalignment");
      applyStimulus(1, 0, 1, 32'h00001003, 32'h5, 4'hF, 0, 0, 0);
      applyStimulus(1, 1, 0, 32'h00001000, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("alias_1000", rdata[1], 32'h5);
      applyStimulus(1, 1, 0, 32'h00000000, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("alias_0000", rdata[1], 32'h5);

      $display("[TB] random traffic");
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) begin
            applyStimulus(d, 0, 1, 32'(i * 4), $urandom, 4'hF, 0, 0, 0);
         end
      end
      for (int n = 0; n < 40; n++) begin
         int d;
         bit is_rd;
         d = int'($urandom_range(0, 1));
         is_rd = 1'($urandom_range(0, 1));
         applyStimulus(d, is_rd, !is_rd, $urandom & 32'hFFFF_F03F, $urandom,
                       4'($urandom), 1'($urandom_range(0, 1)), 0, 0);
      end

      $display("[TB] protocol errors");
      applyStimulus(0, 1, 1, 32'h180, 32'h0F0F0F0F, 4'hF, 0, 0, 0);
      checkOutput("both_perr", 32'(err[0]), 32'd1);
      applyStimulus(0, 1, 0, 32'h180, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("both_const", rdata[0], 32'h0F0F0F0F);
      applyStimulus(0, 0, 1, 32'h1C0, 32'hCAFE0000, 4'hF, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h140, 32'h55, 4'hF, 0, 1, 32'h1C0);
      applyStimulus(0, 1, 0, 32'h140, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("chg_orig_const", rdata[0], 32'h55);
      applyStimulus(0, 1, 0, 32'h1C0, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("chg_other_const", rdata[0], 32'hCAFE0000);
      checkOutput("perr_sticky", 32'(err[0]), 32'd1);
      checkOutput("perr_d1_clean", 32'(err[1]), 32'd0);

      $display("[TB] reset during RESP");
      rd[0] = 1'b1; addr[0] = 32'h40;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
      end
      checkOutput("pre_rst_resp", 32'(resp[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_resp", 32'(resp[0]), 32'd0);
      checkOutput("rst_async_rdata", rdata[0], 32'd0);
      checkOutput("rst_async_perr", 32'(err[0]), 32'd0);
      idleInputs(0);
      releaseReset();

      $display("[TB] reset mid-write");
      applyStimulus(0, 0, 1, 32'h10, 32'h0, 4'hF, 0, 0, 0);
      rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'h12345678; be[0] = 4'hF;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midwr_resp", 32'(resp[0]), 32'd0);
      idleInputs(0);
      releaseReset();
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0, 0);
      checkOutput("midwr_discard", rdata[0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Synthesizable responder for the single-outstanding-request memory interface driven by the mp0 CPU. Accepts one read or write, waits a configurable number of cycles, then returns a one-cycle `mem_resp` pulse, plus read data for loads. Sits between the CPU top level and a word-organized storage array. Serves as both the simulation memory and the FPGA on-chip memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: log2 of word depth; the array is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 3: cycles from request first visible to `mem_resp` high. Legal range 1–15.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request, held until `mem_resp`.
- `mem_write` input 1: write request, held until `mem_resp`.
- `mem_byte_enable` input 4: per-byte write strobe; bit i enables `mem_wdata[8i+7:8i]`. Ignored for reads.
- `mem_address` input 32: byte address. Word index is `mem_address[ADDR_WIDTH+1:2]`. Bits [1:0] and the upper bits are ignored, so upper addresses alias.
- `mem_wdata` input 32: write data.
- `mem_resp` output 1: one-cycle completion pulse.
- `mem_rdata` output 32: read data, valid when `mem_resp` is high on a read.
- `protocol_err` output 1: sticky error flag.

## Operation
State machine (`mem_resp_state_t`): IDLE, WAIT, RESP.
- **IDLE**: when `mem_read` or `mem_write` is high at the edge:
  - Latch the op, word index, `mem_wdata` and `mem_byte_enable`.
  - Load the down-counter with `LATENCY-1`.
  - Go to RESP if `LATENCY`=1, otherwise go to WAIT.
- **WAIT**: decrement the counter each edge. On the edge where the counter equals 1, go to RESP.
- **Commit**: happens on the edge that enters RESP.
  - Write: update only the enabled bytes of the latched word. `mem_byte_enable`=0000 is legal and is a no-op write that still responds.
  - Read: load `mem_rdata` from the latched word.
- **RESP**: `mem_resp`=1 for exactly this cycle, then unconditionally return to IDLE. A request still high in RESP is not sampled. A new request is accepted in the IDLE cycle that follows, earliest.
- **Both requests high in IDLE**: treat as a write and set `protocol_err`.
- **Inputs change in WAIT**: if `mem_address`, `mem_read` or `mem_write` differs from the latched values during WAIT, set `protocol_err`. The transaction still completes using the latched values.
- **Outputs between transactions**:
  - `mem_rdata` holds its last read value and is unchanged by writes.
  - `protocol_err` clears only on reset.
- **Storage**: array contents are not reset. There is no read-during-write hazard because only one transaction is in flight at a time.

## Timing
- **Reset values**: state IDLE, `mem_resp`=0, `mem_rdata`=0, `protocol_err`=0, counter 0.
- **Latency**: a request first visible in cycle N gives `mem_resp` high in cycle N+`LATENCY`.
- **Throughput**: back-to-back requests are spaced at least `LATENCY`+1 cycles apart, start to start.
- **Registered outputs**: `mem_resp`, `mem_rdata` and `protocol_err` come directly from flops, with no combinational path from any input.
- **Reset mid-transaction**: asserting `rst_n` low in WAIT or RESP causes:
  - immediate return to IDLE;
  - `mem_resp` drops asynchronously;
  - an uncommitted write is discarded, so the array is unchanged.

## Structure
- Add `mem_resp_state_t` to the shared `rv32i_types` package, alongside `rv32i_opcode`.
- Also add the constant `MEM_MAX_LATENCY = 15` to that package, used to size the counter (4 bits).
- Sub-module `byte_ram`: 2^ADDR_WIDTH x 32 array with a 4-bit byte write enable and synchronous read. Instantiated once.
- The FSM, latches, counter and error logic stay in `memory_responder`.

## Test plan
- **Read after write, LATENCY=3**: write 0xDEADBEEF to 0x40 with be=1111, then read 0x40. Expect `mem_resp` 3 cycles after each request and `mem_rdata`=0xDEADBEEF.
- **Byte enables**: word 0x80=0x11223344, then write 0xAABBCCDD with be=0101, then read. Expect 0x11BB33DD.
- **LATENCY=1 with a CPU-like driver**: a fetch, a load and a store back-to-back. Expect each `mem_resp` in the cycle after the request, one pulse each, and no double response.
- **Aliasing and misalignment, ADDR_WIDTH=10**: write 0x5 to 0x00001003, then read 0x00001000 (expect 0x5) and read 0x00000000 (expect 0x5).
- **Protocol errors**:
  - `mem_read` and `mem_write` both high: expect write semantics and `protocol_err`=1.
  - Address changed during WAIT: the transaction uses the original address and `protocol_err` stays 1.
- **Reset mid-write**: write 0x12345678 to 0x10, where the word previously held 0x0, and pulse `rst_n` low in WAIT. Expect `mem_resp`=0 immediately, then a later read of 0x10 returns 0x0.
